// File: rtl/portal_ind_pkg.sv
// portal_ind_pkg: shared channel-width, message-size and entry helpers for the indication portal
package portal_ind_pkg;
  localparam int IND_DATA_W = 32;
  typedef struct packed {
    logic                  last;
    logic [IND_DATA_W-1:0] data;
  } ind_entry_t;
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [15:0] msg_size(input logic [255:0] sizes, input int idx);
    return sizes[16*idx +: 16];
  endfunction
endpackage

// File: rtl/portal_ind_chan_fifo.sv
// portal_ind_chan_fifo: one channel's message-aware FIFO with length checking
module portal_ind_chan_fifo
  import portal_ind_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter int          DATA_W   = IND_DATA_W,
  parameter logic [15:0] MSG_SIZE = 16'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              push_last,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              ready,
  output logic              has_msg,
  output logic              err,
  output logic [DATA_W-1:0] head_data
);
  localparam int AW = $clog2(DEPTH);
  ind_entry_t    mem_q [DEPTH];
  ind_entry_t    head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d, msg_cnt_q, msg_cnt_d;
  logic [15:0]   wcnt_q, wcnt_d, n;
  logic          err_q, err_d, push_ok, pop_ok;
  always_comb begin
    head      = mem_q[rd_ptr_q];
    ready     = count_q < (AW+1)'(DEPTH);
    has_msg   = msg_cnt_q != '0;
    push_ok   = push && ready;
    pop_ok    = pop && has_msg;
    n         = wcnt_q + 16'd1;
    wr_ptr_d  = wr_ptr_q + AW'(push_ok);
    rd_ptr_d  = rd_ptr_q + AW'(pop_ok);
    count_d   = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    msg_cnt_d = msg_cnt_q + (AW+1)'(push_ok && push_last) - (AW+1)'(pop_ok && head.last);
    wcnt_d    = !push_ok ? wcnt_q : push_last ? '0 : n;
    err_d     = err_q | (push_ok && (push_last ? n != MSG_SIZE : n == MSG_SIZE));
  end
  assign head_data = DATA_W'(head.data);
  assign err       = err_q;
  // Storage is not reset: an empty channel never exposes or pops its head.
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_ptr_q] <= '{last: push_last, data: IND_DATA_W'(push_data)};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      msg_cnt_q <= '0;
      wcnt_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      msg_cnt_q <= msg_cnt_d;
      wcnt_q    <= wcnt_d;
      err_q     <= err_d;
    end
endmodule

// File: rtl/portal_indication_mux.sv
// portal_indication_mux: multi-channel indication portal with per-channel FIFOs, interrupt and size lookup
module portal_indication_mux
  import portal_ind_pkg::*;
#(
  parameter int                     NUM_CHAN  = 4,
  parameter int                     DEPTH     = 16,
  parameter int                     DATA_W    = IND_DATA_W,
  parameter logic [16*NUM_CHAN-1:0] MSG_SIZES = {NUM_CHAN{16'd1}},
  localparam int                    CW        = chan_w(NUM_CHAN)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN_ind,
  output logic                RDY_ind,
  input  logic [CW-1:0]       ind_chan,
  input  logic [DATA_W-1:0]   ind_data,
  input  logic                ind_last,
  input  logic [CW-1:0]       rd_chan,
  output logic                RDY_indications_first,
  output logic [DATA_W-1:0]   indications_first,
  input  logic                EN_indications_deq,
  output logic                RDY_indications_deq,
  output logic [NUM_CHAN-1:0] indications_notEmpty,
  input  logic                intr_enable,
  output logic                intr_status,
  output logic [31:0]         intr_channel,
  input  logic [15:0]         messageSize_size_methodNumber,
  output logic [15:0]         messageSize_size,
  output logic                RDY_messageSize_size,
  output logic [NUM_CHAN-1:0] proto_err
);
  logic [NUM_CHAN-1:0] ready, has_msg;
  logic [DATA_W-1:0]   head [NUM_CHAN];
  logic [DATA_W-1:0]   rd_head;
  logic                rd_ok;
  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    portal_ind_chan_fifo #(
      .DEPTH(DEPTH),
      .DATA_W(DATA_W),
      .MSG_SIZE(msg_size(256'(MSG_SIZES), c))
    ) u_fifo (
      .clk(CLK),
      .rst_n(RST_N),
      .push(EN_ind && ind_chan == CW'(c)),
      .push_last(ind_last),
      .push_data(ind_data),
      .pop(EN_indications_deq && rd_chan == CW'(c)),
      .ready(ready[c]),
      .has_msg(has_msg[c]),
      .err(proto_err[c]),
      .head_data(head[c])
    );
  end
  // Descending scan so the lowest pending channel wins the interrupt encode.
  always_comb begin
    RDY_ind          = 1'b0;
    rd_ok            = 1'b0;
    rd_head          = '0;
    intr_channel     = '0;
    messageSize_size = '0;
    for (int c = NUM_CHAN - 1; c >= 0; c--) begin
      if (ind_chan == CW'(c)) RDY_ind = ready[c];
      if (rd_chan == CW'(c)) begin
        rd_ok   = has_msg[c];
        rd_head = head[c];
      end
      if (has_msg[c]) intr_channel = 32'(c) + 32'd1;
      if (messageSize_size_methodNumber == 16'(c)) messageSize_size = msg_size(256'(MSG_SIZES), c);
    end
  end
  assign indications_notEmpty  = has_msg;
  assign RDY_indications_first = rd_ok;
  assign RDY_indications_deq   = rd_ok;
  assign indications_first     = rd_ok ? rd_head : '0;
  assign intr_status           = intr_enable & |has_msg;
  assign RDY_messageSize_size  = 1'b1;
endmodule

// File: tb/tb_portal_indication_mux.sv
// tb_portal_indication_mux: directed and random stimulus against a queue-based message model
module tb_portal_indication_mux;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        EN_ind = 1'b0, ind_last = 1'b0, EN_indications_deq = 1'b0, intr_enable = 1'b1;
  logic [1:0]  ind_chan = '0, rd_chan = '0;
  logic [31:0] ind_data = '0;
  logic [15:0] mn = '0;
  logic        RDY_ind, RDY_indications_first, RDY_indications_deq, intr_status, RDY_messageSize_size;
  logic [31:0] indications_first, intr_channel;
  logic [3:0]  indications_notEmpty, proto_err;
  logic [15:0] messageSize_size;
  always #5 CLK = ~CLK;
  portal_indication_mux #(
    .NUM_CHAN(4), .DEPTH(16), .DATA_W(32),
    .MSG_SIZES({16'd1, 16'd1, 16'd3, 16'd1})
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .EN_ind(EN_ind), .RDY_ind(RDY_ind), .ind_chan(ind_chan),
    .ind_data(ind_data), .ind_last(ind_last), .rd_chan(rd_chan),
    .RDY_indications_first(RDY_indications_first), .indications_first(indications_first),
    .EN_indications_deq(EN_indications_deq), .RDY_indications_deq(RDY_indications_deq),
    .indications_notEmpty(indications_notEmpty), .intr_enable(intr_enable),
    .intr_status(intr_status), .intr_channel(intr_channel),
    .messageSize_size_methodNumber(mn), .messageSize_size(messageSize_size),
    .RDY_messageSize_size(RDY_messageSize_size), .proto_err(proto_err)
  );
  int checks = 0, errors = 0;
  logic [32:0] mq [4][$];
  int wc [4];
  bit perr [4];
  int sizes [4] = '{1, 3, 1, 1};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic bit msg_ready(input int c);
    for (int i = 0; i < mq[c].size(); i++) if (mq[c][i][32]) return 1'b1;
    return 1'b0;
  endfunction
  task automatic check_all();
    logic [3:0]  ne = '0, pe = '0;
    logic [31:0] head = '0;
    int          lo = 0;
    int          sz = 0;
    for (int c = 3; c >= 0; c--) begin
      ne[c] = msg_ready(c);
      pe[c] = perr[c];
      if (ne[c]) lo = c + 1;
    end
    if (ne[rd_chan]) head = mq[rd_chan][0][31:0];
    if (mn < 16'd4) sz = sizes[mn];
    chk("rdy_ind", RDY_ind, mq[ind_chan].size() < 16);
    chk("not_empty", indications_notEmpty, ne);
    chk("rdy_first", RDY_indications_first, ne[rd_chan]);
    chk("rdy_deq", RDY_indications_deq, ne[rd_chan]);
    chk("first", indications_first, head);
    chk("intr_status", intr_status, intr_enable && ne != 4'b0);
    chk("intr_channel", intr_channel, lo);
    chk("proto_err", proto_err, pe);
    chk("msg_size", messageSize_size, sz);
    chk("rdy_size", RDY_messageSize_size, 1);
  endtask
  task automatic cycle(input bit en, input int ch, input logic [31:0] d, input bit l,
                       input bit dq, input int rc);
    bit push_ok, pop_ok;
    int n;
    EN_ind = en; ind_chan = 2'(ch); ind_data = d; ind_last = l;
    EN_indications_deq = dq; rd_chan = 2'(rc);
    #4;
    check_all();
    push_ok = en && mq[ch].size() < 16;
    pop_ok = dq && msg_ready(rc);
    @(posedge CLK);
    if (pop_ok) void'(mq[rc].pop_front());
    if (push_ok) begin
      n = wc[ch] + 1;
      if (l ? n != sizes[ch] : n == sizes[ch]) perr[ch] = 1'b1;
      wc[ch] = l ? 0 : n;
      mq[ch].push_back({l, d});
    end
    #1;
  endtask
  task automatic do_reset();
    EN_ind = 1'b0;
    EN_indications_deq = 1'b0;
    RST_N = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      mq[c].delete();
      wc[c] = 0;
      perr[c] = 1'b0;
    end
    check_all();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask
  initial begin
    @(posedge CLK);
    #1;
    do_reset();
    cycle(0, 0, 0, 0, 0, 0);
    chk("reset_rdy_ind", RDY_ind, 1);
    chk("reset_first", indications_first, 0);
    chk("reset_intr_channel", intr_channel, 0);
    // three-word message on ch1
    cycle(1, 1, 32'hA, 0, 0, 1);
    cycle(1, 1, 32'hB, 0, 0, 1);
    chk("partial_hidden", indications_notEmpty, 4'b0000);
    cycle(1, 1, 32'hC, 1, 0, 1);
    chk("msg_visible", indications_notEmpty, 4'b0010);
    chk("msg_intr", intr_status, 1);
    chk("msg_intr_chan", intr_channel, 2);
    chk("head_a", indications_first, 32'hA);
    cycle(0, 0, 0, 0, 1, 1);
    chk("head_b", indications_first, 32'hB);
    chk("tail_visible", indications_notEmpty, 4'b0010);
    cycle(0, 0, 0, 0, 1, 1);
    chk("head_c", indications_first, 32'hC);
    cycle(0, 0, 0, 0, 1, 1);
    chk("drained", indications_notEmpty, 4'b0000);
    // fill ch0, then overflow and push+deq while full
    for (int i = 0; i < 16; i++) cycle(1, 0, 32'h100 + i, 1, 0, 1);
    chk("full_rdy", RDY_ind, 0);
    cycle(1, 0, 32'hDEAD, 1, 0, 1);
    cycle(1, 0, 32'hBEEF, 1, 1, 0);
    chk("full_pushdeq_rdy", RDY_ind, 1);
    chk("full_pushdeq_head", indications_first, 32'h101);
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, 0, 1, 0);
    chk("ch0_drained", indications_notEmpty, 4'b0000);
    // interrupt priority and masking
    do_reset();
    cycle(1, 2, 32'h22, 1, 0, 0);
    cycle(1, 3, 32'h33, 1, 0, 0);
    chk("intr_lowest", intr_channel, 3);
    cycle(0, 0, 0, 0, 1, 2);
    chk("intr_next", intr_channel, 4);
    intr_enable = 1'b0;
    #1;
    chk("intr_masked", intr_status, 0);
    chk("intr_chan_unmasked", intr_channel, 4);
    intr_enable = 1'b1;
    // short message on ch1 sets sticky error
    do_reset();
    cycle(1, 1, 32'h1, 0, 0, 1);
    cycle(1, 1, 32'h2, 1, 0, 1);
    chk("short_err", proto_err, 4'b0010);
    chk("short_readable", indications_notEmpty, 4'b0010);
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'h10 + i, i == 2, 0, 1);
    chk("err_sticky", proto_err, 4'b0010);
    do_reset();
    cycle(0, 0, 0, 0, 0, 0);
    chk("err_cleared", proto_err, 4'b0000);
    mn = 16'd1;
    #1;
    chk("size_m1", messageSize_size, 3);
    mn = 16'd9;
    #1;
    chk("size_m9", messageSize_size, 0);
    // reset mid-message
    cycle(1, 1, 32'h5, 0, 0, 1);
    cycle(1, 0, 32'h6, 1, 0, 1);
    do_reset();
    cycle(0, 0, 0, 0, 0, 0);
    chk("mid_reset_empty", indications_notEmpty, 4'b0000);
    for (int i = 0; i < 3000; i++) begin
      intr_enable = 1'($urandom_range(0, 1));
      mn = 16'($urandom_range(0, 6));
      if (i % 700 == 699) do_reset();
      else cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
